// File: rtl/aim_tile_sched.sv
// Tile scheduler for the associative index matcher: fetches weights, starts AIM,
// captures first hit per lane, then drains hits as a compacted valid/ready stream.
module aim_tile_sched #(
    parameter int LANES   = 32,
    parameter int POS_W   = 9,
    parameter int ITE_W   = 4,
    parameter int TILE_W  = 8,
    parameter int TIMEOUT = 64,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [TILE_W-1:0]      i_cmd_tiles,
    input  logic [ITE_W-1:0]       i_cmd_ite,
    output logic                   o_wt_req,
    output logic [TILE_W-1:0]      o_wt_tile,
    input  logic                   i_wt_ack,
    output logic                   o_aim_start,
    output logic [ITE_W-1:0]       o_aim_ite,
    input  logic                   i_aim_finish,
    input  logic [LANES-1:0]       i_aim_valid,
    input  logic [LANES*POS_W-1:0] i_aim_pos,
    output logic                   o_hit_valid,
    input  logic                   i_hit_ready,
    output logic [LANE_W-1:0]      o_hit_lane,
    output logic [POS_W-1:0]       o_hit_pos,
    output logic [TILE_W-1:0]      o_hit_tile,
    output logic                   o_hit_last,
    output logic                   o_tile_done,
    output logic                   o_done,
    output logic                   o_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_DONE
    } state_e;

    state_e              state_q;
    logic                cmd_ready_q;
    logic                wt_req_q;
    logic                aim_start_q;
    logic                done_q;
    logic                err_q;
    logic [TILE_W-1:0]   tiles_q;
    logic [TILE_W-1:0]   tile_q;
    logic [ITE_W-1:0]    ite_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LANES-1:0]    mask_q;
    logic [POS_W-1:0]    pos_q [LANES];

    logic [LANE_W-1:0]   sel_lane;
    logic                one_left;
    logic                hit_valid;
    logic                hit_hs;
    logic                tile_done;

    // Lowest set mask bit is the record presented downstream.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (mask_q[l]) sel_lane = LANE_W'(l);
        end
    end

    assign one_left  = (mask_q & (mask_q - 1'b1)) == '0;
    assign hit_valid = (state_q == S_DRAIN) && (mask_q != '0);
    assign hit_hs    = hit_valid && i_hit_ready;
    assign tile_done = (state_q == S_DRAIN) && ((mask_q == '0) || (hit_hs && one_left));

    assign o_cmd_ready = cmd_ready_q;
    assign o_wt_req    = wt_req_q;
    assign o_wt_tile   = tile_q;
    assign o_aim_start = aim_start_q;
    assign o_aim_ite   = ite_q;
    assign o_hit_valid = hit_valid;
    assign o_hit_lane  = sel_lane;
    assign o_hit_pos   = pos_q[sel_lane];
    assign o_hit_tile  = tile_q;
    assign o_hit_last  = hit_valid && one_left;
    assign o_tile_done = tile_done;
    assign o_done      = done_q;
    assign o_err       = err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            wt_req_q    <= 1'b0;
            aim_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tiles_q     <= '0;
            tile_q      <= '0;
            ite_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            // NOTE: the position store is reset too, so no stale position survives an aborted command.
            for (int l = 0; l < LANES; l++) pos_q[l] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (i_cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        tiles_q     <= i_cmd_tiles;
                        ite_q       <= i_cmd_ite;
                        tile_q      <= '0;
                        err_q       <= 1'b0;
                        wt_req_q    <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (i_wt_ack) begin
                        wt_req_q    <= 1'b0;
                        aim_start_q <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    aim_start_q <= 1'b0;
                    mask_q      <= '0;
                    cnt_q       <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // First hit per lane wins; only a clean 1 on valid latches.
                    for (int l = 0; l < LANES; l++) begin
                        if (i_aim_valid[l] == 1'b1 && !mask_q[l]) begin
                            mask_q[l] <= 1'b1;
                            pos_q[l]  <= i_aim_pos[l*POS_W +: POS_W];
                        end
                    end
                    if (i_aim_finish) begin
                        state_q <= S_DRAIN;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (hit_hs) mask_q[sel_lane] <= 1'b0;
                    if (tile_done) begin
                        if (tile_q == tiles_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            tile_q   <= tile_q + 1'b1;
                            wt_req_q <= 1'b1;
                            state_q  <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aim_tile_sched.sv
// Directed bench for aim_tile_sched: drives fetch/AIM/downstream handshakes by hand
// and checks every observable output against hand-computed values.
module tb_aim_tile_sched;

    localparam int LANES  = 32;
    localparam int POS_W  = 9;
    localparam int ITE_W  = 4;
    localparam int TILE_W = 8;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b1;
    logic                   i_cmd_valid = 1'b0;
    logic                   o_cmd_ready;
    logic [TILE_W-1:0]      i_cmd_tiles = '0;
    logic [ITE_W-1:0]       i_cmd_ite = '0;
    logic                   o_wt_req;
    logic [TILE_W-1:0]      o_wt_tile;
    logic                   i_wt_ack = 1'b0;
    logic                   o_aim_start;
    logic [ITE_W-1:0]       o_aim_ite;
    logic                   i_aim_finish = 1'b0;
    logic [LANES-1:0]       i_aim_valid = '0;
    logic [LANES*POS_W-1:0] i_aim_pos = '0;
    logic                   o_hit_valid;
    logic                   i_hit_ready = 1'b1;
    logic [4:0]             o_hit_lane;
    logic [POS_W-1:0]       o_hit_pos;
    logic [TILE_W-1:0]      o_hit_tile;
    logic                   o_hit_last;
    logic                   o_tile_done;
    logic                   o_done;
    logic                   o_err;

    int total = 0;
    int bad   = 0;

    aim_tile_sched dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_tiles(i_cmd_tiles), .i_cmd_ite(i_cmd_ite),
        .o_wt_req(o_wt_req), .o_wt_tile(o_wt_tile), .i_wt_ack(i_wt_ack),
        .o_aim_start(o_aim_start), .o_aim_ite(o_aim_ite),
        .i_aim_finish(i_aim_finish), .i_aim_valid(i_aim_valid), .i_aim_pos(i_aim_pos),
        .o_hit_valid(o_hit_valid), .i_hit_ready(i_hit_ready),
        .o_hit_lane(o_hit_lane), .o_hit_pos(o_hit_pos), .o_hit_tile(o_hit_tile),
        .o_hit_last(o_hit_last), .o_tile_done(o_tile_done),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pos(input int lane, input int pos);
        i_aim_pos[lane*POS_W +: POS_W] = POS_W'(pos);
    endtask

    task automatic cmd(input int tiles, input int ite);
        chk("cmd_ready_idle", o_cmd_ready, 1);
        i_cmd_valid = 1'b1;
        i_cmd_tiles = TILE_W'(tiles);
        i_cmd_ite   = ITE_W'(ite);
        tick();
        i_cmd_valid = 1'b0;
        chk("cmd_ready_busy", o_cmd_ready, 0);
        chk("aim_ite", o_aim_ite, ite);
    endtask

    // Bounded wait for the weight request, ack it, and follow the start pulse into WAIT.
    task automatic go_tile(input int tile);
        int n = 0;
        while (!o_wt_req && n < 20) begin
            tick();
            n++;
        end
        chk("wt_req_seen", o_wt_req, 1);
        chk("wt_tile", o_wt_tile, tile);
        i_wt_ack = 1'b1;
        tick();
        i_wt_ack = 1'b0;
        chk("aim_start", o_aim_start, 1);
        chk("wt_req_drop", o_wt_req, 0);
        tick();
        chk("aim_start_once", o_aim_start, 0);
    endtask

    task automatic aim(input logic [LANES-1:0] v, input logic fin);
        i_aim_valid  = v;
        i_aim_finish = fin;
        tick();
        i_aim_valid  = '0;
        i_aim_finish = 1'b0;
    endtask

    task automatic hit(input int lane, input int pos, input int tile, input int last, input int td);
        chk("hit_valid", o_hit_valid, 1);
        chk("hit_lane", o_hit_lane, lane);
        chk("hit_pos", o_hit_pos, pos);
        chk("hit_tile", o_hit_tile, tile);
        chk("hit_last", o_hit_last, last);
        chk("tile_done", o_tile_done, td);
        tick();
    endtask

    initial begin
        logic [LANES-1:0] v;

        // Reset state
        #1 i_rst_n = 1'b0;
        #2;
        chk("rst_cmd_ready", o_cmd_ready, 0);
        chk("rst_wt_req", o_wt_req, 0);
        chk("rst_hit_valid", o_hit_valid, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("ready_after_rst", o_cmd_ready, 1);

        // One tile, lanes 3 and 17 hit together with finish
        cmd(0, 1);
        go_tile(0);
        set_pos(3, 5);
        set_pos(17, 40);
        aim((32'd1 << 3) | (32'd1 << 17), 1'b1);
        hit(3, 5, 0, 0, 0);
        hit(17, 40, 0, 1, 1);
        chk("t1_done", o_done, 1);
        chk("t1_no_hit", o_hit_valid, 0);
        tick();
        chk("t1_done_pulse", o_done, 0);
        chk("t1_ready", o_cmd_ready, 1);

        // Three tiles, middle one empty
        cmd(2, 0);
        go_tile(0);
        set_pos(0, 7);
        aim(32'd1, 1'b1);
        hit(0, 7, 0, 1, 1);
        chk("t2_no_done0", o_done, 0);
        go_tile(1);
        aim('0, 1'b1);
        chk("t2_empty_valid", o_hit_valid, 0);
        chk("t2_empty_tdone", o_tile_done, 1);
        tick();
        chk("t2_tdone_pulse", o_tile_done, 0);
        go_tile(2);
        set_pos(30, 1);
        set_pos(31, 511);
        aim((32'd1 << 30) | (32'd1 << 31), 1'b1);
        hit(30, 1, 2, 0, 0);
        hit(31, 511, 2, 1, 1);
        chk("t2_done", o_done, 1);
        tick();

        // First hit per lane wins; an X on a valid bit never latches
        cmd(0, 3);
        go_tile(0);
        set_pos(4, 2);
        set_pos(6, 9);
        v = 32'h10;
        v[6] = 1'bx;
        aim(v, 1'b0);
        set_pos(4, 34);
        aim(32'h10, 1'b1);
        hit(4, 2, 0, 1, 1);
        chk("t3_done", o_done, 1);
        tick();

        // Downstream stall on the second record
        cmd(0, 0);
        go_tile(0);
        set_pos(1, 11);
        set_pos(2, 22);
        set_pos(9, 99);
        aim((32'd1 << 1) | (32'd1 << 2) | (32'd1 << 9), 1'b1);
        hit(1, 11, 0, 0, 0);
        i_hit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", o_hit_valid, 1);
            chk("stall_lane", o_hit_lane, 2);
            chk("stall_pos", o_hit_pos, 22);
            chk("stall_last", o_hit_last, 0);
            chk("stall_tdone", o_tile_done, 0);
            tick();
        end
        i_hit_ready = 1'b1;
        hit(2, 22, 0, 0, 0);
        hit(9, 99, 0, 1, 1);
        chk("t4_done", o_done, 1);
        tick();

        // AIM never finishes: abort after 64 WAIT cycles
        cmd(0, 0);
        go_tile(0);
        repeat (63) tick();
        chk("to_no_done_yet", o_done, 0);
        chk("to_no_err_yet", o_err, 0);
        tick();
        chk("to_err", o_err, 1);
        chk("to_done", o_done, 1);
        chk("to_no_hits", o_hit_valid, 0);
        tick();
        chk("to_err_sticky", o_err, 1);
        chk("to_done_pulse", o_done, 0);

        // Next command clears the error; reset lands mid-drain
        cmd(1, 0);
        chk("err_cleared", o_err, 0);
        go_tile(0);
        set_pos(5, 3);
        aim(32'd1 << 5, 1'b1);
        chk("pre_rst_valid", o_hit_valid, 1);
        i_rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", o_hit_valid, 0);
        chk("mid_rst_tdone", o_tile_done, 0);
        chk("mid_rst_wt_req", o_wt_req, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_ready", o_cmd_ready, 0);
        i_rst_n = 1'b1;
        tick();
        chk("post_rst_ready", o_cmd_ready, 1);
        chk("post_rst_valid", o_hit_valid, 0);
        chk("post_rst_done", o_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
